// File: rtl/regfile_sb_pkg.sv
// Shared constants and state encoding for the scoreboarded register file.
package regfile_sb_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam logic RST_ACT = 1'b0;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;
endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on issue, cleared on writeback.
module regfile_sb_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     set_vld,
  input  logic [ADDR_W-1:0]        set_addr,
  input  logic                     clr0,
  input  logic [ADDR_W-1:0]        clr0_addr,
  input  logic                     clr1,
  input  logic [ADDR_W-1:0]        clr1_addr,
  input  logic [NUM_RD*ADDR_W-1:0] look_addr,
  output logic [NUM_RD-1:0]        look_busy
);
  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] busy_q, busy_d;

  // A new producer supersedes the one writing back, so set wins over clear.
  always_comb begin
    busy_d = busy_q;
    for (int k = 1; k < DEPTH; k++) begin
      if (set_vld && set_addr == ADDR_W'(k))
        busy_d[k] = 1'b1;
      else if ((clr0 && clr0_addr == ADDR_W'(k)) || (clr1 && clr1_addr == ADDR_W'(k)))
        busy_d[k] = 1'b0;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ACT) busy_q <= '0;
    else                busy_q <= busy_d;
  end

  always_comb begin
    look_busy = '0;
    for (int i = 0; i < NUM_RD; i++)
      look_busy[i] = busy_q[look_addr[i*ADDR_W +: ADDR_W]];
  end
endmodule

// File: rtl/regfile_sb.sv
// Integer register file: two writeback ports, forwarding reads, busy scoreboard,
// and a post-reset zero sweep of the array.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic [DATA_W-1:0]        wdata1,
  input  logic [NUM_RD-1:0]        re,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rbusy,
  input  logic                     iss_valid,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic                     init_done
);
  localparam int DEPTH = 2**ADDR_W;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   regs_q [DEPTH];
  logic [DATA_W-1:0]   regs_d [DEPTH];
  logic                ready, out_en, w0, w1;
  logic [NUM_RD-1:0]   sb_busy;
  logic [ADDR_W-1:0]   ra [NUM_RD];

  assign ready     = (state_q == ST_READY);
  assign init_done = ready;
  assign out_en    = (rst != RST_ACT) && ready;
  // x0 is never written, so writes to it are dropped here along with INIT-time writes.
  assign w0        = ready && we0 && (waddr0 != '0);
  assign w1        = ready && we1 && (waddr1 != '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    regs_d  = regs_q;
    case (state_q)
      ST_INIT: begin
        regs_d[cnt_q] = '0;
        cnt_d         = cnt_q + 1'b1;
        if (cnt_q == ADDR_W'(DEPTH-1)) state_d = ST_READY;
      end
      ST_READY: begin
        if (w0) regs_d[waddr0] = wdata0;
        if (w1) regs_d[waddr1] = wdata1;
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ACT) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Array contents are untrusted across reset; the sweep rewrites them.
  always_ff @(posedge clk) begin
    if (rst != RST_ACT) regs_q <= regs_d;
  end

  regfile_sb_scoreboard #(.ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) u_sb (
    .clk       (clk),
    .rst       (rst),
    .set_vld   (ready && iss_valid),
    .set_addr  (iss_addr),
    .clr0      (w0),
    .clr0_addr (waddr0),
    .clr1      (w1),
    .clr1_addr (waddr1),
    .look_addr (raddr),
    .look_busy (sb_busy)
  );

  for (genvar g = 0; g < NUM_RD; g++) begin : g_ra
    assign ra[g] = raddr[g*ADDR_W +: ADDR_W];
  end

  always_comb begin
    rdata = '0;
    rbusy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (out_en && re[i] && ra[i] != '0) begin
        if (w1 && waddr1 == ra[i])      rdata[i*DATA_W +: DATA_W] = wdata1;
        else if (w0 && waddr0 == ra[i]) rdata[i*DATA_W +: DATA_W] = wdata0;
        else                            rdata[i*DATA_W +: DATA_W] = regs_q[ra[i]];
        // A value being forwarded this cycle is by definition not outstanding.
        rbusy[i] = sb_busy[i] && !((w0 && waddr0 == ra[i]) || (w1 && waddr1 == ra[i]));
      end
    end
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb with a per-cycle reference model and literal checks.
module tb_regfile_sb;
  logic        clk = 1'b0;
  logic        rst;
  logic        we0, we1, iss_valid;
  logic [4:0]  waddr0, waddr1, iss_addr;
  logic [31:0] wdata0, wdata1;
  logic [1:0]  re, rbusy;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic        init_done;

  int n_chk = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  logic [31:0] m_regs [32];
  bit          m_busy [32];
  bit          m_ready = 1'b0;
  int          m_cnt = 0;

  regfile_sb dut (
    .clk(clk), .rst(rst),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .re(re), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .init_done(init_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural register and busy state, updated per clock edge.
  always @(posedge clk) begin
    if (!rst) begin
      m_ready = 1'b0;
      m_cnt   = 0;
      for (int k = 0; k < 32; k++) m_busy[k] = 1'b0;
    end else if (!m_ready) begin
      m_cnt++;
      if (m_cnt == 32) begin
        m_ready = 1'b1;
        for (int k = 0; k < 32; k++) m_regs[k] = 32'h0;
      end
    end else begin
      for (int k = 1; k < 32; k++) begin
        if (iss_valid && iss_addr == 5'(k)) m_busy[k] = 1'b1;
        else if ((we0 && waddr0 == 5'(k)) || (we1 && waddr1 == 5'(k))) m_busy[k] = 1'b0;
      end
      if (we0 && waddr0 != 0) m_regs[waddr0] = wdata0;
      if (we1 && waddr1 != 0) m_regs[waddr1] = wdata1;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("init_done", {31'b0, init_done}, {31'b0, m_ready});
      for (int i = 0; i < 2; i++) begin
        automatic logic [4:0]  a  = raddr[i*5 +: 5];
        automatic logic [31:0] ed = 32'h0;
        automatic bit          eb = 1'b0;
        if (rst && m_ready && re[i] && a != 0) begin
          if (we1 && waddr1 == a)      ed = wdata1;
          else if (we0 && waddr0 == a) ed = wdata0;
          else                         ed = m_regs[a];
          eb = m_busy[a] && !((we0 && waddr0 == a) || (we1 && waddr1 == a));
        end
        check($sformatf("rdata%0d", i), rdata[i*32 +: 32], ed);
        check($sformatf("rbusy%0d", i), {31'b0, rbusy[i]}, {31'b0, eb});
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    we0 = 0; we1 = 0; iss_valid = 0;
    waddr0 = 0; waddr1 = 0; wdata0 = 0; wdata1 = 0; iss_addr = 0;
  endtask

  task automatic rd(input int p, input logic [4:0] a);
    raddr[p*5 +: 5] = a;
    re[p] = 1'b1;
  endtask

  task automatic wait_init(input string name);
    int cyc = 0;
    while (!init_done && cyc < 100) begin
      tick();
      cyc++;
    end
    check(name, cyc, 32);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    re = 2'b00; raddr = '0; rst = 1'b0;
    tick();
    cmp_en = 1'b1;
    check("reset_init_done", {31'b0, init_done}, 32'h0);
    repeat (2) tick();
    rst = 1'b1;
    wait_init("init_latency");

    // Sweep left every register at zero.
    for (int k = 1; k < 32; k++) begin
      rd(0, 5'(k)); rd(1, 5'(32 - k));
      @(negedge clk);
      check("sweep_zero", rdata[31:0], 32'h0);
      tick();
    end

    // Forwarding, then stored value.
    we0 = 1; waddr0 = 5; wdata0 = 32'hDEADBEEF; rd(0, 5);
    @(negedge clk); check("fwd_same_cycle", rdata[31:0], 32'hDEADBEEF);
    tick(); idle();
    @(negedge clk); check("fwd_stored", rdata[31:0], 32'hDEADBEEF);
    tick();

    // Dual-write collision: port 1 wins.
    we0 = 1; waddr0 = 7; wdata0 = 32'h11111111;
    we1 = 1; waddr1 = 7; wdata1 = 32'h22222222; rd(0, 7);
    @(negedge clk); check("collide_fwd", rdata[31:0], 32'h22222222);
    tick(); idle();
    @(negedge clk); check("collide_stored", rdata[31:0], 32'h22222222);
    tick();

    // Scoreboard set then writeback clear.
    iss_valid = 1; iss_addr = 9; rd(1, 9);
    tick(); idle();
    @(negedge clk); check("busy_after_iss", {31'b0, rbusy[1]}, 32'h1);
    repeat (3) tick();
    we1 = 1; waddr1 = 9; wdata1 = 32'h00000099;
    @(negedge clk);
    check("busy_fwd_cycle", {31'b0, rbusy[1]}, 32'h0);
    check("busy_fwd_data", rdata[63:32], 32'h00000099);
    tick(); idle();
    @(negedge clk); check("busy_cleared", {31'b0, rbusy[1]}, 32'h0);
    tick();

    // Set beats clear on x3.
    iss_valid = 1; iss_addr = 3; rd(0, 3);
    tick();
    iss_valid = 1; iss_addr = 3; we0 = 1; waddr0 = 3; wdata0 = 32'h33;
    @(negedge clk); check("race_fwd_notbusy", {31'b0, rbusy[0]}, 32'h0);
    tick(); idle();
    @(negedge clk);
    check("race_still_busy", {31'b0, rbusy[0]}, 32'h1);
    check("race_data", rdata[31:0], 32'h33);
    tick();

    // x0 is immune to issue and writes.
    iss_valid = 1; iss_addr = 0;
    we0 = 1; waddr0 = 0; wdata0 = 32'hFFFFFFFF;
    we1 = 1; waddr1 = 0; wdata1 = 32'hFFFFFFFF;
    rd(0, 0); rd(1, 0);
    @(negedge clk); check("x0_fwd", rdata[31:0], 32'h0);
    tick(); idle();
    @(negedge clk);
    check("x0_data", rdata[63:32], 32'h0);
    check("x0_busy", {30'b0, rbusy}, 32'h0);
    tick();

    // Mixed pattern through both ports for the model to track.
    for (int k = 10; k < 18; k++) begin
      we0 = 1; waddr0 = 5'(k); wdata0 = 32'h01010101 * k;
      we1 = 1; waddr1 = 5'(k + 8); wdata1 = 32'hF0F0F0F0 ^ k;
      iss_valid = (k % 3 == 0); iss_addr = 5'(k + 1);
      rd(0, 5'(k - 1)); rd(1, 5'(k + 8));
      tick();
    end
    idle();

    // Mid-operation reset.
    we0 = 1; waddr0 = 4; wdata0 = 32'hA5A5A5A5; iss_valid = 1; iss_addr = 6;
    tick(); idle();
    rd(0, 4); rd(1, 6);
    @(negedge clk);
    check("pre_rst_x4", rdata[31:0], 32'hA5A5A5A5);
    check("pre_rst_x6_busy", {31'b0, rbusy[1]}, 32'h1);
    tick();
    rst = 0;
    tick();
    rst = 1;
    check("mid_rst_init_done", {31'b0, init_done}, 32'h0);
    we0 = 1; waddr0 = 4; wdata0 = 32'h12345678;
    we1 = 1; waddr1 = 30; wdata1 = 32'hCAFEF00D;
    iss_valid = 1; iss_addr = 6;
    wait_init("reinit_latency");
    idle();
    rd(0, 4); rd(1, 6);
    @(negedge clk);
    check("reinit_x4", rdata[31:0], 32'h0);
    check("reinit_x6_busy", {31'b0, rbusy[1]}, 32'h0);
    tick();
    rd(1, 30);
    @(negedge clk); check("reinit_x30", rdata[63:32], 32'h0);
    tick();

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised integer register file for the next core revision.
- NUM_RD combinational read ports and two writeback ports: port 0 for ALU, port 1 for load/mem.
- Same-cycle write-to-read forwarding.
- Per-register pending-write scoreboard, used by decode for stall decisions.
- Hardware zero-sweep of the array after reset, so no initial-block preload is needed.
- Sits between decode (reads/issue) and writeback (writes).

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; DEPTH = 2**ADDR_W.
- NUM_RD, 2, number of read ports.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-low: rst==0 resets at the clock edge.
- we0  in  1  write enable, port 0.
- waddr0  in  ADDR_W  write address, port 0.
- wdata0  in  DATA_W  write data, port 0.
- we1  in  1  write enable, port 1.
- waddr1  in  ADDR_W  write address, port 1.
- wdata1  in  DATA_W  write data, port 1.
- re  in  NUM_RD  per-port read enable.
- raddr  in  NUM_RD*ADDR_W  read addresses; port i uses bits [i*ADDR_W +: ADDR_W].
- rdata  out  NUM_RD*DATA_W  read data; port i uses bits [i*DATA_W +: DATA_W].
- rbusy  out  NUM_RD  read address has an outstanding producer.
- iss_valid  in  1  an instruction issues with a destination register.
- iss_addr  in  ADDR_W  destination register of the issuing instruction.
- init_done  out  1  array sweep complete; block is usable.

Behaviour:
- Reset (rst==0 at an edge):
  - FSM goes to INIT, sweep counter = 0.
  - All busy bits = 0; init_done = 0.
  - rdata and rbusy are forced to 0 while rst==0 or while in INIT.
- INIT state:
  - Each cycle writes 0 to regs[cnt], then cnt++.
  - After writing index DEPTH-1, goes to READY on the next edge; init_done = 1 from that edge onward.
  - Duration is exactly DEPTH cycles after rst deasserts.
  - we0, we1 and iss_valid are ignored during INIT.
- READY state:
  - Stays in READY until reset.
  - Reset mid-operation returns to INIT and restarts the sweep from index 0; register contents are not trusted.
- Register 0:
  - Never written and never busy.
  - Reads of address 0 return 0 with rbusy = 0.
- Writes:
  - Committed at the edge, one cycle after the request is presented.
  - If we0 and we1 target the same non-zero address in one cycle, port 1 data wins.
- Read port i (combinational, zero latency), in priority order:
  - re[i]==0 → rdata 0, rbusy 0.
  - addr 0 → 0.
  - match with an active we1 → wdata1.
  - match with an active we0 → wdata0.
  - otherwise regs[addr].
- rbusy[i]:
  - Equals busy[raddr_i] AND NOT (a write to raddr_i is active this cycle).
  - A forwarded value is therefore never reported busy.
- Scoreboard, per entry, next state:
  - Set if iss_valid && iss_addr==k && k!=0.
  - Else clear if (we0 && waddr0==k) || (we1 && waddr1==k).
  - Else hold.
  - Set beats clear on simultaneous set and clear: a new producer supersedes the one writing back.
  - A writeback to a non-busy register is legal and writes normally.
- No X propagation: all outputs are defined in every state.

Decomposition:
- Shared package / defines file gets:
  - DATA_W and ADDR_W defaults.
  - INIT and READY state encodings (1-bit enum).
  - Active-low reset level constant, replacing the old active-high enable macro for this block.
- Natural sub-module: regfile_sb_scoreboard.
  - Holds DEPTH busy bits, the set/clear priority, and NUM_RD lookup outputs.
  - Takes the same clk/rst.
- Array, forwarding muxes and the INIT FSM stay in regfile_sb.

Test Plan:
- Reset sweep: hold rst=0 for 3 cycles, release, wait.
  → init_done rises exactly 32 cycles after release.
  → Reads of x1..x31 all return 0x00000000.
- Forwarding: we0=1, waddr0=5, wdata0=0xDEADBEEF, raddr port 0 = 5 in the same cycle.
  → rdata0 = 0xDEADBEEF combinationally.
  → Next cycle, with we0=0, rdata0 is still 0xDEADBEEF.
- Dual-write collision: we0 x7=0x11111111 and we1 x7=0x22222222 in the same cycle.
  → rdata (forwarded) and the stored value are both 0x22222222.
- Scoreboard: iss x9 → rbusy for x9 = 1 on the next cycle; we1 x9 a few cycles later.
  → rbusy = 0 in the write cycle (forwarded) and stays 0 afterward.
- Set/clear race: x3 busy; iss_valid x3 and we0 x3 in the same cycle.
  → x3 is still busy after the edge.
  → x0: iss x0 and we x0=0xFFFFFFFF → x0 reads 0, rbusy 0.
- Mid-operation reset: with x4=0xA5A5A5A5 and x6 busy, pulse rst=0 for 1 cycle.
  → init_done = 0 and busy cleared at that edge.
  → After 32 cycles, x4 reads 0.
  → Writes issued during INIT have no effect.
